// File: rtl/os_tx_scheduler.sv
// Ordered-set transmit scheduler for link training: walks the Gen3 or Gen4
// ordered-set sequence, counting os_sent rising edges per phase, then holds DATA.
module os_tx_scheduler #(
    parameter int SLOS_REPS = 2,
    parameter int TS_REPS   = 16,
    parameter int TS4_REPS  = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic       fsm_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gen4,
    input  logic       abort,
    input  logic       os_sent,
    output logic [3:0] d_sel,
    output logic       busy,
    output logic       link_ready,
    output logic       err
);

    localparam logic [3:0] ST_SLOS1  = 4'd0;
    localparam logic [3:0] ST_SLOS2  = 4'd1;
    localparam logic [3:0] ST_G3_TS1 = 4'd2;
    localparam logic [3:0] ST_G3_TS2 = 4'd3;
    localparam logic [3:0] ST_G4_TS1 = 4'd4;
    localparam logic [3:0] ST_G4_TS2 = 4'd5;
    localparam logic [3:0] ST_G4_TS3 = 4'd6;
    localparam logic [3:0] ST_G4_TS4 = 4'd7;
    localparam logic [3:0] ST_DATA   = 4'd8;
    localparam logic [3:0] ST_IDLE   = 4'd9;
    localparam logic [3:0] ST_ERROR  = 4'd10;

    localparam logic [7:0]  SLOS_N  = (SLOS_REPS == 0) ? 8'd1 : 8'(SLOS_REPS);
    localparam logic [7:0]  TS_N    = (TS_REPS == 0)   ? 8'd1 : 8'(TS_REPS);
    localparam logic [7:0]  TS4_N   = (TS4_REPS == 0)  ? 8'd1 : 8'(TS4_REPS);
    localparam logic [12:0] WDOG_TO = 13'(TIMEOUT);

    logic [3:0]  state_q, state_d;
    logic [7:0]  evt_cnt_q, evt_cnt_d;
    logic [12:0] wdog_q, wdog_d;
    logic        os_sent_q;
    logic [3:0]  d_sel_q, d_sel_d;
    logic        busy_q, busy_d;
    logic        link_ready_q, link_ready_d;
    logic        err_q, err_d;
    logic        evt;

    function automatic logic [7:0] phase_target(input logic [3:0] s);
        case (s)
            ST_SLOS1, ST_SLOS2: phase_target = SLOS_N;
            ST_G4_TS4:          phase_target = TS4_N;
            default:            phase_target = TS_N;
        endcase
    endfunction

    function automatic logic [3:0] next_phase(input logic [3:0] s);
        case (s)
            ST_SLOS1:  next_phase = ST_SLOS2;
            ST_SLOS2:  next_phase = ST_G3_TS1;
            ST_G3_TS1: next_phase = ST_G3_TS2;
            ST_G4_TS1: next_phase = ST_G4_TS2;
            ST_G4_TS2: next_phase = ST_G4_TS3;
            ST_G4_TS3: next_phase = ST_G4_TS4;
            default:   next_phase = ST_DATA;
        endcase
    endfunction

    assign evt = os_sent & ~os_sent_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        wdog_d    = wdog_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) state_d = gen4 ? ST_G4_TS1 : ST_SLOS1;
            end
            ST_DATA: ;
            default: begin
                // An event beats a simultaneous watchdog expiry.
                if (evt) begin
                    wdog_d = '0;
                    if (evt_cnt_q + 8'd1 == phase_target(state_q))
                        state_d = next_phase(state_q);
                    else
                        evt_cnt_d = evt_cnt_q + 8'd1;
                end else if (wdog_q >= WDOG_TO) begin
                    state_d = ST_ERROR;
                end else begin
                    wdog_d = wdog_q + 13'd1;
                end
            end
        endcase

        if (abort) state_d = ST_IDLE;

        if (state_d != state_q) begin
            evt_cnt_d = '0;
            wdog_d    = '0;
        end

        // Outputs are decoded from the next state so the registered copies track state_q.
        busy_d       = (state_d <= ST_G4_TS4);
        link_ready_d = (state_d == ST_DATA);
        err_d        = (state_d == ST_ERROR);
        d_sel_d      = (state_d <= ST_DATA) ? state_d : 4'hF;
    end

    always_ff @(posedge fsm_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            evt_cnt_q    <= '0;
            wdog_q       <= '0;
            os_sent_q    <= 1'b0;
            d_sel_q      <= 4'hF;
            busy_q       <= 1'b0;
            link_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            evt_cnt_q    <= evt_cnt_d;
            wdog_q       <= wdog_d;
            os_sent_q    <= os_sent;
            d_sel_q      <= d_sel_d;
            busy_q       <= busy_d;
            link_ready_q <= link_ready_d;
            err_q        <= err_d;
        end
    end

    assign d_sel      = d_sel_q;
    assign busy       = busy_q;
    assign link_ready = link_ready_q;
    assign err        = err_q;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Directed self-checking bench for os_tx_scheduler with default parameters.
module tb_os_tx_scheduler;

    logic       fsm_clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       gen4 = 1'b0;
    logic       abort = 1'b0;
    logic       os_sent = 1'b0;
    logic [3:0] d_sel;
    logic       busy;
    logic       link_ready;
    logic       err;

    int n_checks = 0;
    int n_fails  = 0;

    os_tx_scheduler dut (
        .fsm_clk    (fsm_clk),
        .rst        (rst),
        .start      (start),
        .gen4       (gen4),
        .abort      (abort),
        .os_sent    (os_sent),
        .d_sel      (d_sel),
        .busy       (busy),
        .link_ready (link_ready),
        .err        (err)
    );

    always #5 fsm_clk = ~fsm_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic send_event();
        os_sent = 1'b1;
        tick();
        os_sent = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic g4);
        start = 1'b1;
        gen4  = g4;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic run_phase(input string tag, input logic [3:0] ds, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(d_sel), 32'(ds));
            send_event();
        end
    endtask

    initial begin
        int n;

        // Reset with other inputs active
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("rst_dsel", 32'(d_sel), 32'hF);
        check("rst_busy", 32'(busy), 0);
        check("rst_link", 32'(link_ready), 0);
        check("rst_err", 32'(err), 0);

        // os_sent ignored in IDLE
        send_event();
        check("idle_ignore_os", 32'(d_sel), 32'hF);

        // Gen3 flow; first SLOS1 event is a 10-cycle-long pulse
        do_start(1'b0);
        check("g3_start_dsel", 32'(d_sel), 0);
        check("g3_start_busy", 32'(busy), 1);
        os_sent = 1'b1;
        repeat (10) tick();
        os_sent = 1'b0;
        tick();
        check("long_pulse_one_evt", 32'(d_sel), 0);
        send_event();
        run_phase("g3_slos2", 4'd1, 2);
        run_phase("g3_ts1", 4'd2, 16);
        run_phase("g3_ts2", 4'd3, 16);
        check("g3_data_dsel", 32'(d_sel), 8);
        check("g3_data_link", 32'(link_ready), 1);
        check("g3_data_busy", 32'(busy), 0);
        repeat (3) send_event();
        do_start(1'b1);
        check("data_hold", 32'(d_sel), 8);
        do_abort();
        check("abort_data_dsel", 32'(d_sel), 32'hF);
        check("abort_data_link", 32'(link_ready), 0);

        // Gen4 flow; gen4 dropped while busy must not matter
        do_start(1'b1);
        gen4 = 1'b0;
        check("g4_start_dsel", 32'(d_sel), 4);
        run_phase("g4_ts1", 4'd4, 16);
        run_phase("g4_ts2", 4'd5, 16);
        run_phase("g4_ts3", 4'd6, 16);
        run_phase("g4_ts4", 4'd7, 16);
        check("g4_data_dsel", 32'(d_sel), 8);
        check("g4_data_link", 32'(link_ready), 1);
        do_abort();

        // Abort coincident with the final TS4 event
        do_start(1'b1);
        repeat (48) send_event();
        run_phase("g4b_ts4", 4'd7, 15);
        os_sent = 1'b1;
        abort   = 1'b1;
        tick();
        os_sent = 1'b0;
        abort   = 1'b0;
        check("abort_evt_dsel", 32'(d_sel), 32'hF);
        check("abort_evt_link", 32'(link_ready), 0);
        tick();
        check("abort_evt_stay", 32'(d_sel), 32'hF);

        // Watchdog in G3_TS1
        do_start(1'b0);
        repeat (4) send_event();
        check("to_in_ts1", 32'(d_sel), 2);
        repeat (4000) tick();
        check("to_not_yet", 32'(err), 0);
        n = 4000;
        while (!err && n < 5000) begin
            tick();
            n++;
        end
        check("to_window", 32'(n >= 4090 && n <= 4100), 1);
        check("to_err", 32'(err), 1);
        check("to_dsel", 32'(d_sel), 32'hF);
        check("to_busy", 32'(busy), 0);
        send_event();
        check("err_ignore_os", 32'(d_sel), 32'hF);
        do_start(1'b1);
        check("err_restart_dsel", 32'(d_sel), 4);
        check("err_restart_err", 32'(err), 0);
        do_abort();

        // Reset mid-SLOS2, start ignored while busy
        do_start(1'b0);
        do_start(1'b1);
        check("start_ignored_busy", 32'(d_sel), 0);
        repeat (2) send_event();
        send_event();
        check("slos2_one_evt", 32'(d_sel), 1);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("mid_rst_dsel", 32'(d_sel), 32'hF);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_err", 32'(err), 0);
        do_start(1'b0);
        check("rst_restart_slos1", 32'(d_sel), 0);
        send_event();
        check("rst_restart_cnt0", 32'(d_sel), 0);
        send_event();
        check("rst_restart_slos2", 32'(d_sel), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/os_tx_scheduler.md
OS_TX_SCHEDULER -- requirements
Module: os_tx_scheduler

Interface
REQ-001 Parameter SLOS_REPS, default 2, number of SLOS1 and of SLOS2 ordered sets per Gen3 training; 0 is treated as 1.
REQ-002 Parameter TS_REPS, default 16, number of TS1/TS2 (Gen3) and TS1/TS2/TS3 (Gen4) ordered sets per phase; 0 is treated as 1.
REQ-003 Parameter TS4_REPS, default 16, number of Gen4 TS4 ordered sets; 0 is treated as 1.
REQ-004 Parameter TIMEOUT, default 4096, maximum cycles between counted os_sent pulses before error.
REQ-005 fsm_clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to begin link training.
REQ-008 gen4  in  1  training flow select, sampled only with start: 1 = Gen4, 0 = Gen3.
REQ-009 abort  in  1  immediate return to IDLE from any state.
REQ-010 os_sent  in  1  ordered-set-complete pulse from the lane 0 transmit datapath.
REQ-011 d_sel  out  4  ordered-set select to the datapath: 0 SLOS1, 1 SLOS2, 2 G3 TS1, 3 G3 TS2, 4 G4 TS1, 5 G4 TS2, 6 G4 TS3, 7 TS4, 8 transport data, F idle.
REQ-012 busy  out  1  high in any training state.
REQ-013 link_ready  out  1  high in DATA.
REQ-014 err  out  1  high in ERROR.

Function
REQ-015 All outputs are registered; d_sel, busy, link_ready and err are decoded from the state register only.
REQ-016 States and d_sel: IDLE=F, SLOS1=0, SLOS2=1, G3_TS1=2, G3_TS2=3, G4_TS1=4, G4_TS2=5, G4_TS3=6, G4_TS4=7, DATA=8, ERROR=F.
REQ-017 An os_sent event is a rising edge: os_sent=1 while the registered previous value os_sent_q=0; only events are counted.
REQ-018 IDLE: start=1 with gen4=0 moves to SLOS1; start=1 with gen4=1 moves to G4_TS1; d_sel changes on the cycle after start.
REQ-019 Gen3 sequence: SLOS1 (SLOS_REPS events) -> SLOS2 (SLOS_REPS) -> G3_TS1 (TS_REPS) -> G3_TS2 (TS_REPS) -> DATA.
REQ-020 Gen4 sequence: G4_TS1 (TS_REPS) -> G4_TS2 (TS_REPS) -> G4_TS3 (TS_REPS) -> G4_TS4 (TS4_REPS) -> DATA.
REQ-021 An 8-bit event counter clears on every state entry and increments on each event; on the event that makes it equal the phase count, the state advances on the next clock edge.
REQ-022 A 13-bit watchdog clears on every state entry and on every event, increments each cycle otherwise in training states, and moves to ERROR when it reaches TIMEOUT.
REQ-023 If the watchdog reaching TIMEOUT and an event occur in the same cycle, the event wins and no error is raised.
REQ-024 DATA holds d_sel=8 indefinitely; the watchdog and event counter are frozen at 0; os_sent is ignored.
REQ-025 ERROR holds until start (restarts training per gen4, as from IDLE) or abort (to IDLE).
REQ-026 abort=1 forces IDLE on the next edge from every state and has priority over start, events and timeout.
REQ-027 start is ignored outside IDLE and ERROR; os_sent is ignored in IDLE and ERROR.
REQ-028 gen4 is latched with accepted start; changes while busy have no effect.

Reset
REQ-029 rst=1 at a clock edge forces state IDLE, d_sel=F, busy=0, link_ready=0, err=0, counters=0, os_sent_q=0, regardless of any other input, including mid-training.
REQ-030 rst has priority over abort and start.

Verification
REQ-031 Gen3: start, gen4=0, os_sent pulses on demand -> d_sel 0 for 2 events, 1 for 2, 2 for 16, 3 for 16, then 8 with link_ready=1.
REQ-032 Gen4 with TS4_REPS=16 -> d_sel 4,5,6 for 16 events each, 7 for 16, then 8; exactly 64 events consumed.
REQ-033 os_sent held high 10 cycles in SLOS1 -> counted as one event.
REQ-034 No os_sent for 4096 cycles in G3_TS1 -> err=1, d_sel=F, busy=0; then start with gen4=1 -> d_sel=4.
REQ-035 abort and an os_sent event in the same cycle in G4_TS4 -> IDLE next cycle, d_sel=F, no advance to DATA.
REQ-036 rst pulsed during SLOS2 after 1 event -> all outputs at reset values; subsequent start restarts from SLOS1 with counter 0.
